segment_frame_collector: RTL and testbench

- Downstream consumer of the if/else segment-combine stages.
- Captures the 32-bit segment_N_combine results of the unrolled segments, in index order, into an internal frame buffer.
- Streams the completed frame out over a valid/ready interface, followed by a running-sum checksum beat.
- Flags sequencing errors and any segments dropped while a frame is draining.

---
 rtl/segment_frame_collector.sv | 80 ++++++++
 tb/tb_segment_frame_collector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/segment_frame_collector.sv
// segment_frame_collector: gathers in-order segment words into a frame, then streams the frame and its running-sum checksum.
module segment_frame_collector #(
  parameter int DATA_W  = 32,
  parameter int NUM_SEG = 8,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seg_valid,
  input  logic [IDX_W-1:0]  seg_index,
  input  logic [DATA_W-1:0] segment_combine,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_is_sum,
  output logic              seq_err,
  output logic              drop_err,
  output logic [15:0]       frame_cnt,
  output logic              busy
);
  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [IDX_W-1:0]  exp_q, exp_d;
  logic [IDX_W:0]    ptr_q, ptr_d, ptr_nx;
  logic [DATA_W-1:0] sum_q, sum_d, out_data_q, out_data_d;
  logic              seq_err_q, seq_err_d, drop_err_q, drop_err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] seg_buf_q [NUM_SEG];
  logic              wr, last_seg, adv, sum_done;
  assign busy       = state_q == DRAIN;
  assign out_valid  = busy;
  assign out_is_sum = ptr_q == (IDX_W+1)'(NUM_SEG);
  assign out_last   = out_is_sum;
  assign out_data   = out_data_q;
  assign seq_err    = seq_err_q;
  assign drop_err   = drop_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign wr       = !busy && seg_valid && seg_index == exp_q;
  assign last_seg = exp_q == IDX_W'(NUM_SEG - 1);
  assign adv      = busy && out_ready;
  assign sum_done = adv && out_is_sum;
  assign ptr_nx   = ptr_q + 1'b1;
  always_comb begin
    state_d     = wr && last_seg ? DRAIN : sum_done ? COLLECT : state_q;
    exp_d       = wr ? exp_q + 1'b1 : exp_q;
    sum_d       = sum_done ? '0 : wr ? sum_q + segment_combine : sum_q;
    ptr_d       = sum_done || !busy ? '0 : adv ? ptr_nx : ptr_q;
    out_data_d  = wr && last_seg ? seg_buf_q[0]
                : adv && !out_is_sum ? (ptr_nx == (IDX_W+1)'(NUM_SEG) ? sum_q : seg_buf_q[ptr_nx[IDX_W-1:0]])
                : out_data_q;
    seq_err_d   = seq_err_q | (!busy && seg_valid && seg_index != exp_q);
    drop_err_d  = drop_err_q | (busy && seg_valid);
    frame_cnt_d = frame_cnt_q + 16'(sum_done);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      exp_q       <= '0;
      ptr_q       <= '0;
      sum_q       <= '0;
      out_data_q  <= '0;
      seq_err_q   <= 1'b0;
      drop_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      seq_err_q   <= seq_err_d;
      drop_err_q  <= drop_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) seg_buf_q[exp_q] <= segment_combine;
  end
endmodule

// File: tb/tb_segment_frame_collector.sv
// tb_segment_frame_collector: directed checks of frame capture, streaming, checksum, error flags and async reset.
module tb_segment_frame_collector;
  logic        clk = 0, reset = 0, seg_valid = 0, out_ready = 0;
  logic [2:0]  seg_index = 0;
  logic [31:0] segment_combine = 0;
  logic [31:0] out_data;
  logic        out_valid, out_last, out_is_sum, seq_err, drop_err, busy;
  logic [15:0] frame_cnt;
  logic [31:0] fr [8];
  int          errors = 0, checks = 0;
  segment_frame_collector dut (
    .clk(clk), .reset(reset), .seg_valid(seg_valid), .seg_index(seg_index),
    .segment_combine(segment_combine), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_is_sum(out_is_sum),
    .seq_err(seq_err), .drop_err(drop_err), .frame_cnt(frame_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic send(input int i, input logic [31:0] d);
    @(negedge clk);
    seg_valid = 1;
    seg_index = 3'(i);
    segment_combine = d;
  endtask
  task automatic send_frame;
    for (int i = 0; i < 8; i++) send(i, fr[i]);
  endtask
  task automatic idle;
    @(negedge clk);
    seg_valid = 0;
  endtask
  task automatic drain(input logic [31:0] sum, input int stall_at, input int stall_len, input int drop_at, input int stop);
    int b = 0, st = 0;
    logic [31:0] exp;
    while (b < stop) begin
      @(negedge clk);
      seg_valid = 0;
      if (b == drop_at) begin
        seg_valid = 1;
        seg_index = 0;
        segment_combine = 32'hDEAD_BEEF;
      end
      exp = b < 8 ? fr[b] : sum;
      check($sformatf("beat%0d valid", b), out_valid, 1);
      check($sformatf("beat%0d busy", b), busy, 1);
      check($sformatf("beat%0d data", b), out_data, exp);
      check($sformatf("beat%0d is_sum", b), out_is_sum, b == 8);
      check($sformatf("beat%0d last", b), out_last, b == 8);
      if (b == stall_at && st < stall_len) begin
        out_ready = 0;
        st++;
      end else begin
        out_ready = 1;
        b++;
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_last", out_last, 0);
    check("rst out_is_sum", out_is_sum, 0);
    check("rst seq_err", seq_err, 0);
    check("rst drop_err", drop_err, 0);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst busy", busy, 0);
    reset = 1;
    for (int i = 0; i < 8; i++) fr[i] = 32'(i + 1);
    send_frame;
    drain(32'h24, -1, 0, -1, 9);
    idle;
    check("f1 out_valid", out_valid, 0);
    check("f1 busy", busy, 0);
    check("f1 frame_cnt", frame_cnt, 1);
    check("f1 seq_err", seq_err, 0);
    check("f1 drop_err", drop_err, 0);
    send_frame;
    drain(32'h24, 3, 5, -1, 9);
    idle;
    check("bp frame_cnt", frame_cnt, 2);
    send(0, 32'h10);
    send(2, 32'h99);
    idle;
    check("seq seq_err", seq_err, 1);
    check("seq busy", busy, 0);
    for (int i = 1; i < 8; i++) send(i, 32'h10 + 32'(i));
    for (int i = 0; i < 8; i++) fr[i] = 32'h10 + 32'(i);
    drain(32'h9C, -1, 0, -1, 9);
    idle;
    check("seq frame_cnt", frame_cnt, 3);
    check("seq drop_err", drop_err, 0);
    for (int i = 0; i < 8; i++) fr[i] = 32'h100 + 32'(i);
    send_frame;
    drain(32'h81C, -1, 0, 2, 9);
    send(0, 32'h200);
    check("drop drop_err", drop_err, 1);
    check("drop out_valid", out_valid, 0);
    check("drop frame_cnt", frame_cnt, 4);
    for (int i = 1; i < 8; i++) send(i, 32'h200 + 32'(i));
    for (int i = 0; i < 8; i++) fr[i] = 32'h200 + 32'(i);
    drain(32'h101C, -1, 0, 8, 9);
    idle;
    check("drop2 frame_cnt", frame_cnt, 5);
    check("drop2 seq_err sticky", seq_err, 1);
    for (int i = 0; i < 8; i++) fr[i] = 32'hFFFF_FFFF;
    send_frame;
    drain(32'hFFFF_FFF8, -1, 0, -1, 9);
    idle;
    check("wrap frame_cnt", frame_cnt, 6);
    for (int i = 0; i < 8; i++) fr[i] = 32'h30 + 32'(i);
    send_frame;
    drain(32'h19C, -1, 0, -1, 4);
    @(negedge clk);
    check("mid beat4 data", out_data, 32'h34);
    out_ready = 0;
    #2 reset = 0;
    #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst busy", busy, 0);
    check("mid rst out_data", out_data, 0);
    check("mid rst out_last", out_last, 0);
    check("mid rst out_is_sum", out_is_sum, 0);
    check("mid rst frame_cnt", frame_cnt, 0);
    check("mid rst seq_err", seq_err, 0);
    check("mid rst drop_err", drop_err, 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) fr[i] = 32'h40 + 32'(i);
    send_frame;
    drain(32'h21C, -1, 0, -1, 9);
    idle;
    check("post frame_cnt", frame_cnt, 1);
    check("post out_valid", out_valid, 0);
    check("post seq_err", seq_err, 0);
    check("post drop_err", drop_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
